// File: rtl/romulator_pkg.sv
// Shared types for the romulator RAM arbitration slice: arbiter state
// encoding and the phi2/rwbar synchronizer depth.
package romulator_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HALT_PEND = 2'd2,
        ST_HALTED    = 2'd3
    } arb_state_t;

    // The CPU drives the RAM address while running or while a halt is pending.
    function automatic logic cpu_owns(input arb_state_t s);
        return (s == ST_RUN) || (s == ST_HALT_PEND);
    endfunction

endpackage

// File: rtl/phi2_edge_sync.sv
// Brings phi2 and rwbar into the clk domain and emits a one-clk phi2 fall
// pulse three clks after the pad edge, with rwbar aligned to that pulse.
module phi2_edge_sync
    import romulator_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic phi2,
    input  logic rwbar,
    output logic phi2_fall,
    output logic rwbar_s
);

    logic [STAGES-1:0] phi2_sr;
    logic [STAGES-1:0] rwbar_sr;
    logic              phi2_d;

    // Reset to phi2 low / read so a release never fabricates a write edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phi2_sr   <= '0;
            rwbar_sr  <= '1;
            phi2_d    <= 1'b0;
            phi2_fall <= 1'b0;
            rwbar_s   <= 1'b1;
        end else begin
            phi2_sr   <= {phi2_sr[STAGES-2:0], phi2};
            rwbar_sr  <= {rwbar_sr[STAGES-2:0], rwbar};
            phi2_d    <= phi2_sr[STAGES-1];
            phi2_fall <= phi2_d & ~phi2_sr[STAGES-1];
            rwbar_s   <= rwbar_sr[STAGES-1];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the onboard RAM between flash loader, CPU and diagnostics.
// Define ARB_DIAG_WRITE_EN to let diagnostics write RAM while halted.
module ram_port_arbiter
    import romulator_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int CFG_W    = 4,
    parameter int HALT_TMO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phi2,
    input  logic              rwbar,
    input  logic              cpu_cs,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_oe,
    input  logic              load_done,
    input  logic [ADDR_W-1:0] flash_addr,
    input  logic [DATA_W-1:0] flash_wdata,
    input  logic              flash_we,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] diag_addr,
    input  logic [DATA_W-1:0] diag_wdata,
    input  logic              diag_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic              halted,
    output logic              rdy,
    input  logic [CFG_W-1:0]  cfg_in,
    output logic [CFG_W-1:0]  cfg
);

    localparam int CNT_W = (HALT_TMO < 2) ? 1 : $clog2(HALT_TMO + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(HALT_TMO);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             phi2_fall, rwbar_s;
    logic             cpu_wr, tmo_hit, diag_wr;
    logic             cfg_loaded;

    phi2_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .phi2      (phi2),
        .rwbar     (rwbar),
        .phi2_fall (phi2_fall),
        .rwbar_s   (rwbar_s)
    );

`ifdef ARB_DIAG_WRITE_EN
    assign diag_wr = diag_we;
`else
    // Read-only diagnostics: the strobe is discarded.
    assign diag_wr = diag_we & 1'b0;
`endif

    assign cpu_wr  = phi2_fall & cpu_cs & ~rwbar_s;
    assign cnt_nxt = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
    // Transition on the clk the counter would reach TMO, so HALTED lands
    // exactly HALT_TMO clks after HALT_PEND entry.
    assign tmo_hit = (cnt_nxt == TMO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_HALT_PEND) ? cnt_nxt : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!load_done) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:      state_d = ST_RUN;
                ST_RUN:       if (halt_req) state_d = ST_HALT_PEND;
                ST_HALT_PEND: begin
                    // A write on the ending fall pulses this clk; HALTED follows.
                    if (!halt_req)                state_d = ST_RUN;
                    else if (phi2_fall || tmo_hit) state_d = ST_HALTED;
                end
                ST_HALTED:    if (!halt_req) state_d = ST_RUN;
                default:      state_d = ST_LOAD;
            endcase
        end
    end

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        cpu_rdata = '0;
        cpu_oe    = 1'b0;
        rdy       = 1'b0;
        halted    = 1'b0;
        if (state_q == ST_LOAD) begin
            ram_addr  = flash_addr;
            ram_wdata = flash_wdata;
            ram_we    = flash_we;
        end else if (cpu_owns(state_q)) begin
            ram_we    = cpu_wr;
            cpu_rdata = ram_rdata;
            cpu_oe    = cpu_cs & rwbar;
            rdy       = (state_q == ST_RUN);
        end else begin
            ram_addr  = diag_addr;
            ram_wdata = diag_wdata;
            ram_we    = diag_wr;
            halted    = 1'b1;
        end
        // Kill any in-flight strobe the instant reset asserts.
        if (!rst) ram_we = 1'b0;
    end

    // Straps are active-low; capture once after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg        <= '0;
            cfg_loaded <= 1'b0;
        end else if (!cfg_loaded) begin
            cfg        <= ~cfg_in;
            cfg_loaded <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter; expected RAM writes are queued when
// stimulus is driven and popped when the DUT strobes ram_we.
module tb_ram_port_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int CFG_W    = 4;
    localparam int HALT_TMO = 255;
`ifdef ARB_DIAG_WRITE_EN
    localparam logic DIAG_WR = 1'b1;
`else
    localparam logic DIAG_WR = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst, phi2, rwbar, cpu_cs, cpu_oe, load_done, flash_we;
    logic              halt_req, diag_we, ram_we, halted, rdy;
    logic [ADDR_W-1:0] cpu_addr, flash_addr, diag_addr, ram_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata, flash_wdata, diag_wdata, ram_wdata, ram_rdata;
    logic [CFG_W-1:0]  cfg_in, cfg;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  we_cnt = 0;

    ram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_W(CFG_W), .HALT_TMO(HALT_TMO)
    ) dut (
        .clk(clk), .rst(rst), .phi2(phi2), .rwbar(rwbar), .cpu_cs(cpu_cs),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_oe(cpu_oe), .load_done(load_done), .flash_addr(flash_addr),
        .flash_wdata(flash_wdata), .flash_we(flash_we), .halt_req(halt_req),
        .diag_addr(diag_addr), .diag_wdata(diag_wdata), .diag_we(diag_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .halted(halted), .rdy(rdy), .cfg_in(cfg_in), .cfg(cfg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ram_we === 1'b1) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge, clear of both edges.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_we(input int budget, output int lat);
        wr_t e;
        lat = 0;
        #1;
        while (ram_we !== 1'b1 && lat < budget) begin
            cyc(1);
            lat++;
        end
        chk("we_seen", 32'(ram_we), 32'd1);
        if (ram_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("we_addr", 32'(ram_addr), 32'(e.addr));
                chk("we_data", 32'(ram_wdata), 32'(e.data));
            end
        end
    endtask

    initial begin
        int lat, base, n;
        rst = 1'b0; phi2 = 1'b1; rwbar = 1'b1; cpu_cs = 1'b1;
        cpu_addr = 16'h1111; cpu_wdata = 8'h00; load_done = 1'b0;
        flash_addr = 16'h0040; flash_wdata = 8'h11; flash_we = 1'b0;
        halt_req = 1'b0; diag_addr = 16'hABCD; diag_wdata = 8'hE7; diag_we = 1'b0;
        ram_rdata = 8'hC3; cfg_in = 4'b1010;

        // Reset state
        cyc(3);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_oe", 32'(cpu_oe), 32'd0);
        chk("rst_cfg", 32'(cfg), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);

        // Release: cfg captures inverted straps, RAM follows the flash loader
        rst = 1'b1;
        cyc(1);
        chk("cfg_load", 32'(cfg), 32'h5);
        chk("load_rdy", 32'(rdy), 32'd0);
        chk("load_addr", 32'(ram_addr), 32'h0040);
        chk("load_oe", 32'(cpu_oe), 32'd0);

        flash_addr = 16'h0010; flash_wdata = 8'h77; flash_we = 1'b1;
        exp_wr(16'h0010, 8'h77);
        wait_we(2, lat);
        chk("flash_lat", 32'(lat), 32'd0);
        flash_we = 1'b0;

        // LOAD -> RUN one clk after load_done
        load_done = 1'b1;
        #1 chk("pre_run_rdy", 32'(rdy), 32'd0);
        cyc(1);
        chk("run_rdy", 32'(rdy), 32'd1);
        chk("run_halted", 32'(halted), 32'd0);
        chk("run_oe", 32'(cpu_oe), 32'd1);
        chk("run_rdata", 32'(cpu_rdata), 32'hC3);
        chk("run_addr", 32'(ram_addr), 32'h1111);

        // CPU write: single pulse 3 clks after the phi2 fall
        cpu_addr = 16'h8000; cpu_wdata = 8'h5A; rwbar = 1'b0;
        #1 chk("wr_oe", 32'(cpu_oe), 32'd0);
        cyc(4);
        base = we_cnt;
        exp_wr(16'h8000, 8'h5A);
        phi2 = 1'b0;
        wait_we(8, lat);
        chk("wr_lat", 32'(lat), 32'd3);
        cyc(4);
        chk("wr_pulses", 32'(we_cnt - base), 32'd1);
        phi2 = 1'b1;
        cyc(4);

        // Read cycle and deselected write: no strobe
        rwbar = 1'b1;
        cyc(3);
        base = we_cnt;
        phi2 = 1'b0;
        cyc(5);
        chk("rd_pulses", 32'(we_cnt - base), 32'd0);
        phi2 = 1'b1; cpu_cs = 1'b0; rwbar = 1'b0;
        cyc(4);
        base = we_cnt;
        phi2 = 1'b0;
        cyc(5);
        chk("nocs_pulses", 32'(we_cnt - base), 32'd0);
        chk("nocs_oe", 32'(cpu_oe), 32'd0);
        phi2 = 1'b1; cpu_cs = 1'b1;
        cyc(4);

        // Halt ended by a phi2 fall carrying a write: write lands, then HALTED
        cpu_addr = 16'h9001; cpu_wdata = 8'h3C;
        halt_req = 1'b1;
        cyc(2);
        chk("hp_rdy", 32'(rdy), 32'd0);
        chk("hp_halted", 32'(halted), 32'd0);
        exp_wr(16'h9001, 8'h3C);
        phi2 = 1'b0;
        wait_we(8, lat);
        chk("hp_wr_halted", 32'(halted), 32'd0);
        cyc(1);
        chk("halt_entry", 32'(halted), 32'd1);
        chk("halt_rdy", 32'(rdy), 32'd0);
        chk("halt_rdata", 32'(cpu_rdata), 32'd0);
        chk("halt_addr", 32'(ram_addr), 32'hABCD);
        chk("halt_wdata", 32'(ram_wdata), 32'hE7);
        chk("halt_we", 32'(ram_we), 32'd0);
        chk("halt_oe", 32'(cpu_oe), 32'd0);

        diag_we = 1'b1;
        #1 chk("diag_we", 32'(ram_we), 32'(DIAG_WR));
        diag_we = 1'b0;

        halt_req = 1'b0;
        cyc(1);
        chk("resume_rdy", 32'(rdy), 32'd1);
        chk("resume_halted", 32'(halted), 32'd0);

        // Halt withdrawn while pending: straight back to RUN
        phi2 = 1'b1; rwbar = 1'b1;
        cyc(4);
        halt_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("abort_halted", 32'(halted), 32'd0);
        end
        chk("abort_pend_rdy", 32'(rdy), 32'd0);
        halt_req = 1'b0;
        cyc(1);
        chk("abort_rdy", 32'(rdy), 32'd1);
        chk("abort_halted2", 32'(halted), 32'd0);

        // phi2 stuck high: HALT_PEND entered on edge 1, HALTED HALT_TMO edges later
        halt_req = 1'b1;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (halted !== 1'b1 && n < 400);
        chk("tmo_cycles", 32'(n), 32'(HALT_TMO + 1));

        // load_done dropped while halted
        flash_addr = 16'h0ABC; flash_wdata = 8'h99;
        load_done = 1'b0;
        #1 chk("ld_pre_halted", 32'(halted), 32'd1);
        cyc(1);
        chk("ld_halted", 32'(halted), 32'd0);
        chk("ld_rdy", 32'(rdy), 32'd0);
        chk("ld_addr", 32'(ram_addr), 32'h0ABC);
        chk("ld_wdata", 32'(ram_wdata), 32'h99);
        halt_req = 1'b0;

        // Reset in the middle of a CPU write strobe
        load_done = 1'b1;
        cyc(1);
        chk("rerun_rdy", 32'(rdy), 32'd1);
        rwbar = 1'b0; cpu_addr = 16'h8002; cpu_wdata = 8'hA5; phi2 = 1'b1;
        cyc(4);
        exp_wr(16'h8002, 8'hA5);
        phi2 = 1'b0;
        wait_we(8, lat);
        cfg_in = 4'b0011;
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(ram_we), 32'd0);
        chk("mid_rst_rdy", 32'(rdy), 32'd0);
        chk("mid_rst_cfg", 32'(cfg), 32'd0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("cfg_reload", 32'(cfg), 32'hC);
        cfg_in = 4'b1111;
        cyc(3);
        chk("cfg_hold", 32'(cfg), 32'hC);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
